// File: rtl/md_sequencer_pkg.sv
// md_sequencer_pkg: shared state encoding and multdiv status codes
package md_sequencer_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_WB   = 2'd2
    } state_t;
    localparam logic [31:0] EXC_NONE       = 32'd0;
    localparam logic [31:0] EXC_MULT       = 32'd4;
    localparam logic [31:0] EXC_DIV        = 32'd5;
    localparam logic [31:0] EXC_MD_TIMEOUT = 32'd6;
endpackage

// File: rtl/md_sequencer_if.sv
// md_sequencer_if: execute-stage <-> multdiv sequencer signal bundle
interface md_sequencer_if;
    logic        ctrl_md_req;
    logic [4:0]  ctrl_md_dest;
    logic        ctrl_md_ready;
    logic [31:0] data_multdiv;
    logic [31:0] exception_MultDiv;
    logic        flush;
    logic        ctrl_md_start;
    logic        stall;
    logic        md_busy;
    logic        ctrl_md_we;
    logic [4:0]  ctrl_md_writeReg;
    logic [31:0] data_md_wb;
    logic        ctrl_excep_we;
    logic [31:0] data_excep;
    modport master (
        output ctrl_md_req, ctrl_md_dest, ctrl_md_ready, data_multdiv, exception_MultDiv, flush,
        input  ctrl_md_start, stall, md_busy, ctrl_md_we, ctrl_md_writeReg, data_md_wb,
               ctrl_excep_we, data_excep
    );
    modport slave (
        input  ctrl_md_req, ctrl_md_dest, ctrl_md_ready, data_multdiv, exception_MultDiv, flush,
        output ctrl_md_start, stall, md_busy, ctrl_md_we, ctrl_md_writeReg, data_md_wb,
               ctrl_excep_we, data_excep
    );
endinterface

// File: rtl/md_sequencer_counter.sv
// md_sequencer_counter: wait-cycle counter with enable and synchronous clear
module md_sequencer_counter #(
    parameter int CNT_W = 6
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);
    logic [CNT_W-1:0] r_count;
    // clear wins over enable so a fresh operation always starts from zero
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr) r_count <= '0;
        else if (i_en) r_count <= r_count + 1'b1;
    end
    assign o_count = r_count;
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: issues one multdiv start, stalls until result or timeout, then one writeback cycle
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input logic           clock,
    input logic           reset,
    md_sequencer_if.slave md
);
    state_t           r_state, w_next;
    logic [4:0]       r_dest;
    logic [31:0]      r_data, r_exc;
    logic [CNT_W-1:0] w_count;
    logic             w_start, w_timeout, w_wb, w_wait;
    md_sequencer_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clock (clock),
        .i_reset (reset),
        .i_en    (w_wait),
        .i_clr   (w_start),
        .o_count (w_count)
    );
    // next-state and outputs; reset blanks every output, including the combinational IDLE terms
    always_comb begin
        w_wait    = r_state == S_WAIT;
        w_start   = ~reset & (r_state == S_IDLE) & md.ctrl_md_req & ~md.flush;
        w_timeout = w_count == CNT_W'(TIMEOUT - 1);
        w_wb      = ~reset & (r_state == S_WB) & ~md.flush;
        w_next    = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = w_start ? S_WAIT : S_IDLE;
            S_WAIT:  w_next = md.flush ? S_IDLE : (md.ctrl_md_ready | w_timeout) ? S_WB : S_WAIT;
            default: w_next = S_IDLE;
        endcase
        md.ctrl_md_start    = w_start;
        md.stall            = w_start | (~reset & w_wait);
        md.md_busy          = ~reset & w_wait;
        md.ctrl_excep_we    = w_wb & (r_exc != EXC_NONE);
        md.ctrl_md_we       = w_wb & (r_exc == EXC_NONE) & (r_dest != 5'd0);
        md.ctrl_md_writeReg = reset ? 5'd0 : r_dest;
        md.data_md_wb       = reset ? 32'd0 : r_data;
        md.data_excep       = reset ? 32'd0 : r_exc;
    end
    // state register plus dest/result latches; a flush in WAIT leaves the result latches untouched
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_dest  <= '0;
            r_data  <= '0;
            r_exc   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) r_dest <= md.ctrl_md_dest;
            if (w_wait && !md.flush && (md.ctrl_md_ready || w_timeout)) begin
                r_data <= md.ctrl_md_ready ? md.data_multdiv : 32'd0;
                r_exc  <= md.ctrl_md_ready ? md.exception_MultDiv : EXC_MD_TIMEOUT;
            end
        end
    end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: transaction-level randomized checking of the mult/div sequencer
module tb_md_sequencer;
    localparam int TIMEOUT = 40;
    typedef struct packed {
        logic        start;
        logic        stall;
        logic        busy;
        logic        md_we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        excep_we;
        logic [31:0] excep;
    } out_t;
    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic [4:0]  m_dest;
    logic [31:0] m_data, m_exc;
    out_t got;
    md_sequencer_if bus ();
    md_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .md    (bus)
    );
    always #5 clock = ~clock;
    assign got = {bus.ctrl_md_start, bus.stall, bus.md_busy, bus.ctrl_md_we, bus.ctrl_md_writeReg,
                  bus.data_md_wb, bus.ctrl_excep_we, bus.data_excep};
    function automatic out_t idle_exp();
        out_t e;
        e = '0;
        e.wreg  = m_dest;
        e.wdata = m_data;
        e.excep = m_exc;
        return e;
    endfunction
    task automatic drive_idle();
        bus.ctrl_md_req       = 1'b0;
        bus.ctrl_md_dest      = 5'($urandom);
        bus.ctrl_md_ready     = 1'b0;
        bus.data_multdiv      = $urandom;
        bus.exception_MultDiv = 32'd0;
        bus.flush             = 1'b0;
    endtask
    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        bus.ctrl_md_req = 1'b1;
        @(negedge clock);
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL reset_cycle: got %h expected %h", got, out_t'('0));
        end
        @(posedge clock); #1;
        reset = 1'b0;
        m_dest = '0; m_data = '0; m_exc = '0;
        drive_idle();
        @(negedge clock);
        tests++;
        if (got !== idle_exp()) begin
            fails++;
            $display("FAIL post_reset_idle: got %h expected %h", got, idle_exp());
        end
        @(posedge clock); #1;
    endtask
    // n: ready arrives n cycles after start (0 = never); f: flush in WAIT cycle f (0 = none); wbf: flush in WB
    task automatic test_op(input string name, input logic [4:0] dest, input int n, input logic [31:0] data,
                           input logic [31:0] exc, input int f, input bit wbf);
        int   k_rt, kend, starts, stalls;
        bit   flushed;
        out_t e;
        k_rt    = (n > 0 && n <= TIMEOUT) ? n : TIMEOUT;
        flushed = f > 0 && f <= k_rt;
        kend    = flushed ? f : k_rt;
        starts  = 0;
        stalls  = 0;
        for (int k = 0; k <= kend; k++) begin
            bus.ctrl_md_req       = 1'b1;
            bus.ctrl_md_dest      = (k == 0) ? dest : 5'($urandom);
            bus.ctrl_md_ready     = (k == n) && (k > 0);
            bus.data_multdiv      = (k == n) ? data : $urandom;
            bus.exception_MultDiv = (k == n) ? exc : 32'($urandom_range(0, 6));
            bus.flush             = (f > 0) && (k == f);
            e       = idle_exp();
            e.start = (k == 0);
            e.stall = 1'b1;
            e.busy  = (k > 0);
            if (k > 0) e.wreg = dest;
            @(negedge clock);
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, e);
            end
            starts += int'(got.start);
            stalls += int'(got.stall);
            @(posedge clock); #1;
            if (k == 0) m_dest = dest;
        end
        if (!flushed) begin
            m_data = (n > 0 && n <= TIMEOUT) ? data : 32'd0;
            m_exc  = (n > 0 && n <= TIMEOUT) ? exc : 32'd6;
        end
        bus.ctrl_md_req   = !flushed;
        bus.ctrl_md_ready = 1'($urandom_range(0, 1));
        bus.flush         = flushed ? 1'b0 : wbf;
        e = idle_exp();
        if (!flushed) begin
            e.md_we    = !wbf && m_exc == 0 && m_dest != 0;
            e.excep_we = !wbf && m_exc != 0;
        end
        @(negedge clock);
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s after-wait cycle: got %h expected %h", name, got, e);
        end
        stalls += int'(got.stall) + int'(got.start);
        tests++;
        if (starts != 1) begin
            fails++;
            $display("FAIL %s start_pulses: got %0d expected 1", name, starts);
        end
        tests++;
        if (stalls != kend + 1) begin
            fails++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, kend + 1);
        end
        @(posedge clock); #1;
    endtask
    task automatic test_mult();
        test_op("mult", 5'd5, 32, 32'h18, 32'd0, 0, 0);
        drive_idle();
    endtask
    task automatic test_div_exception();
        test_op("div_exc", 5'd7, 12, 32'hdead_beef, 32'd5, 0, 0);
        drive_idle();
    endtask
    task automatic test_dest_zero();
        test_op("dest0", 5'd0, 3, 32'h1234_5678, 32'd0, 0, 0);
        drive_idle();
    endtask
    task automatic test_timeout();
        test_op("timeout", 5'd9, 0, 32'h0, 32'd0, 0, 0);
        drive_idle();
        test_op("ready_at_timeout", 5'd10, TIMEOUT, 32'h0000_00aa, 32'd0, 0, 0);
        drive_idle();
    endtask
    task automatic test_flush();
        test_op("flush", 5'd3, 0, 32'h0, 32'd0, 10, 0);
        for (int i = 0; i < 20; i++) begin
            drive_idle();
            if (i == 19) begin
                bus.ctrl_md_ready     = 1'b1;
                bus.exception_MultDiv = 32'd5;
            end
            @(negedge clock);
            tests++;
            if (got !== idle_exp()) begin
                fails++;
                $display("FAIL flush_stray idle %0d: got %h expected %h", i, got, idle_exp());
            end
            @(posedge clock); #1;
        end
        drive_idle();
        @(negedge clock);
        tests++;
        if (got !== idle_exp()) begin
            fails++;
            $display("FAIL flush_stray after: got %h expected %h", got, idle_exp());
        end
        @(posedge clock); #1;
        test_op("wb_flush", 5'd11, 4, 32'h5555_0000, 32'd0, 0, 1);
        drive_idle();
    endtask
    task automatic test_back_to_back();
        test_op("b2b_a", 5'd21, 2, 32'h0000_0a0a, 32'd0, 0, 0);
        test_op("b2b_b", 5'd22, 1, 32'h0000_0b0b, 32'd4, 0, 0);
        test_op("b2b_c", 5'd23, 5, 32'h0000_0c0c, 32'd0, 0, 0);
        drive_idle();
    endtask
    task automatic test_reset_midwait();
        out_t e;
        for (int k = 0; k < 5; k++) begin
            bus.ctrl_md_req   = 1'b1;
            bus.ctrl_md_dest  = (k == 0) ? 5'd17 : 5'($urandom);
            bus.ctrl_md_ready = 1'b0;
            bus.flush         = 1'b0;
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL reset_midwait: got %h expected %h", got, out_t'('0));
        end
        @(posedge clock); #1;
        reset = 1'b0;
        m_dest = '0; m_data = '0; m_exc = '0;
        bus.ctrl_md_dest = 5'd12;
        e = idle_exp();
        e.start = 1'b1;
        e.stall = 1'b1;
        @(negedge clock);
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL reset_restart: got %h expected %h", got, e);
        end
        @(posedge clock); #1;
        m_dest = 5'd12;
        bus.ctrl_md_dest      = 5'($urandom);
        bus.ctrl_md_ready     = 1'b1;
        bus.data_multdiv      = 32'h0000_0077;
        bus.exception_MultDiv = 32'd0;
        @(posedge clock); #1;
        m_data = 32'h0000_0077;
        bus.ctrl_md_ready = 1'b0;
        e = idle_exp();
        e.md_we = 1'b1;
        @(negedge clock);
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL reset_restart_wb: got %h expected %h", got, e);
        end
        @(posedge clock); #1;
        drive_idle();
    endtask
    task automatic test_random();
        int          n, f, sel, gap;
        logic [31:0] exc;
        for (int i = 0; i < 12; i++) begin
            n   = $urandom_range(1, 45);
            f   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 45) : 0;
            sel = $urandom_range(0, 3);
            exc = (sel < 2) ? 32'd0 : (sel == 2) ? 32'd4 : 32'd5;
            test_op("random", 5'($urandom), n, $urandom, exc, f, $urandom_range(0, 7) == 0);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                drive_idle();
                @(negedge clock);
                tests++;
                if (got !== idle_exp()) begin
                    fails++;
                    $display("FAIL random gap: got %h expected %h", got, idle_exp());
                end
                @(posedge clock); #1;
            end
        end
        drive_idle();
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset();
        test_mult();
        test_div_exception();
        test_dest_zero();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_reset_midwait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
